// File: rtl/hilo_ctrl.sv
// HI/LO register pair and sequencer for the 32-cycle Booth multiplier.
// Optional macro HILO_BYPASS_EN forwards new HI/LO values combinationally.
module hilo_ctrl #(
  parameter int MULT_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        mthi_wr,
  input  logic        mtlo_wr,
  input  logic [31:0] wdata,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_lo,
  output logic        mult_resetlocal,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    RUN     = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  state_t      state_r;
  logic [5:0]  count_r;
  logic [31:0] hi_r;
  logic [31:0] lo_r;
  logic        done_r;
  logic        resetlocal_r;
  logic [31:0] hi_s;
  logic [31:0] lo_s;

  // Sequencer, iteration counter and architectural HI/LO registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      count_r      <= 6'd0;
      hi_r         <= 32'd0;
      lo_r         <= 32'd0;
      done_r       <= 1'b0;
      resetlocal_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (mthi_wr) hi_r <= wdata;
          if (mtlo_wr) lo_r <= wdata;
          if (start) begin
            state_r      <= LOAD;
            resetlocal_r <= 1'b1;
          end
        end
        LOAD: begin
          state_r      <= RUN;
          count_r      <= 6'(MULT_CYCLES - 1);
          resetlocal_r <= 1'b0;
        end
        RUN: begin
          // The multiplier performs its last iteration on the edge where count hits zero.
          if (count_r == 6'd0) begin
            state_r <= CAPTURE;
          end else begin
            count_r <= count_r - 6'd1;
          end
        end
        CAPTURE: begin
          hi_r    <= mult_hi;
          lo_r    <= mult_lo;
          done_r  <= 1'b1;
          state_r <= IDLE;
        end
        default: begin
          state_r      <= IDLE;
          resetlocal_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef HILO_BYPASS_EN
  // Forward the value about to be written so consumers see it this cycle.
  always_comb begin
    hi_s = hi_r;
    lo_s = lo_r;
    if (state_r == CAPTURE) begin
      hi_s = mult_hi;
      lo_s = mult_lo;
    end else if (state_r == IDLE) begin
      hi_s = mthi_wr ? wdata : hi_r;
      lo_s = mtlo_wr ? wdata : lo_r;
    end else begin
      hi_s = hi_r;
      lo_s = lo_r;
    end
  end
`else
  // HI/LO outputs come straight from the registers.
  always_comb begin
    hi_s = hi_r;
    lo_s = lo_r;
  end
`endif

  assign busy            = (state_r != IDLE);
  assign done            = done_r;
  assign mult_resetlocal = resetlocal_r;
  assign hi              = hi_s;
  assign lo              = lo_s;

endmodule

// File: tb/tb_hilo_ctrl.sv
// Randomized scoreboard bench for hilo_ctrl with a behavioural multiplier
// and a cycle-count reference model of the architectural HI/LO state.
module tb_hilo_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        mthi_wr = 1'b0;
  logic        mtlo_wr = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] mult_hi = 32'd0;
  logic [31:0] mult_lo = 32'd0;
  logic        mult_resetlocal;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  hilo_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .mthi_wr(mthi_wr), .mtlo_wr(mtlo_wr),
    .wdata(wdata), .mult_hi(mult_hi), .mult_lo(mult_lo),
    .mult_resetlocal(mult_resetlocal), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Operands presented to the multiplier.
  logic [31:0] mul_a = 32'd0;
  logic [31:0] mul_b = 32'd0;

  function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb;
    ea = {{32{a[31]}}, a};
    eb = {{32{b[31]}}, b};
    return ea * eb;
  endfunction

  // Behavioural multiplier: loads on resetlocal, product valid after 32 iterations,
  // shows junk before that so an early capture is visible.
  logic [31:0] ma, mb;
  int          mcnt = 32;
  always @(posedge clk) begin
    if (mult_resetlocal === 1'b1) begin
      ma      <= mul_a;
      mb      <= mul_b;
      mcnt    <= 0;
      mult_hi <= $urandom;
      mult_lo <= $urandom;
    end else if (mcnt < 32) begin
      mcnt <= mcnt + 1;
      if (mcnt == 31) {mult_hi, mult_lo} <= smul(ma, mb);
    end
  end

  // Reference model: edges remaining until capture, architectural HI/LO.
  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          due;
  } exp_t;
  exp_t        sb[$];
  int          cyc = 0;
  int          left = 0;
  logic        m_done = 1'b0;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0, m_phi = 32'd0, m_plo = 32'd0;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Apply one edge with current inputs and advance the model.
  task automatic tick();
    @(posedge clk);
    cyc++;
    m_done = 1'b0;
    if (reset) begin
      m_hi = 32'd0;
      m_lo = 32'd0;
      left = 0;
      sb.delete();
    end else if (left == 0) begin
      if (mthi_wr) m_hi = wdata;
      if (mtlo_wr) m_lo = wdata;
      if (start) begin
        left = 34;
        {m_phi, m_plo} = smul(mul_a, mul_b);
        sb.push_back('{m_phi, m_plo, cyc + 34});
      end
    end else begin
      left--;
      if (left == 0) begin
        m_hi   = m_phi;
        m_lo   = m_plo;
        m_done = 1'b1;
      end
    end
    #1;
  endtask

  function automatic logic [31:0] exp_hi();
    logic [31:0] v;
    v = m_hi;
`ifdef HILO_BYPASS_EN
    if (left == 1) v = m_phi;
    else if (left == 0 && mthi_wr) v = wdata;
`endif
    return v;
  endfunction

  function automatic logic [31:0] exp_lo();
    logic [31:0] v;
    v = m_lo;
`ifdef HILO_BYPASS_EN
    if (left == 1) v = m_plo;
    else if (left == 0 && mtlo_wr) v = wdata;
`endif
    return v;
  endfunction

  // Monitor: per-cycle comparison plus scoreboard pop on every done pulse.
  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("busy", {31'd0, busy}, {31'd0, left != 0});
      chk("resetlocal", {31'd0, mult_resetlocal}, {31'd0, left == 34});
      chk("done", {31'd0, done}, {31'd0, m_done});
      chk("hi", hi, exp_hi());
      chk("lo", lo, exp_lo());
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected_done at cycle %0d: got done with empty scoreboard", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_done_cycle", cyc, e.due);
          if (!(`ifdef HILO_BYPASS_EN mthi_wr `else 1'b0 `endif)) chk("sb_hi", hi, e.hi);
          if (!(`ifdef HILO_BYPASS_EN mtlo_wr `else 1'b0 `endif)) chk("sb_lo", lo, e.lo);
        end
      end else if (sb.size() != 0 && cyc > sb[0].due) begin
        checks++;
        errors++;
        $display("FAIL sb_timeout at cycle %0d: no done, expected by cycle %0d", cyc, sb[0].due);
        void'(sb.pop_front());
      end
    end
  end

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic start_mul(input logic [31:0] a, input logic [31:0] b);
    mul_a = a;
    mul_b = b;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (left != 0 && guard < 200) begin
      tick();
      guard++;
    end
  endtask

  initial begin
    reset = 1'b1;
    run(2);
    reset = 1'b0;
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);

    // mthi then mtlo in IDLE.
    mthi_wr = 1'b1; wdata = 32'hDEADBEEF; tick();
    mthi_wr = 1'b0; mtlo_wr = 1'b1; wdata = 32'h12345678; tick();
    mtlo_wr = 1'b0; wdata = 32'd0;
    chk("mthi_value", hi, 32'hDEADBEEF);
    chk("mtlo_value", lo, 32'h12345678);

    // 7 x 6 with a re-pulsed start and a dropped mthi while busy.
    start_mul(32'd7, 32'd6);
    run(9);
    start = 1'b1; mthi_wr = 1'b1; wdata = 32'd0; mul_a = mul_a; tick();
    start = 1'b0; mthi_wr = 1'b0;
    chk("mthi_dropped_busy", hi, 32'hDEADBEEF);
    wait_idle();
    chk("mul_7x6_hi", hi, 32'h00000000);
    chk("mul_7x6_lo", lo, 32'h0000002A);
    run(2);

    // -3 x 5, then a back-to-back start on the done cycle.
    start_mul(32'hFFFFFFFD, 32'd5);
    begin
      int g = 0;
      while (!m_done && g < 200) begin tick(); g++; end
    end
    chk("mul_neg_hi", hi, 32'hFFFFFFFF);
    chk("mul_neg_lo", lo, 32'hFFFFFFF1);
    start_mul(32'd100000, 32'd300000);
    wait_idle();
    run(1);

    // Reset in the middle of a multiply, then a fresh 2 x 3.
    start_mul(32'd11, 32'd13);
    run(9);
    reset = 1'b1; tick();
    reset = 1'b0;
    chk("midreset_busy", {31'd0, busy}, 32'd0);
    chk("midreset_hi", hi, 32'd0);
    run(40);
    start_mul(32'd2, 32'd3);
    wait_idle();
    chk("mul_2x3_lo", lo, 32'd6);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      reset   = ($urandom_range(0, 299) == 0);
      start   = ($urandom_range(0, 3) == 0);
      mthi_wr = ($urandom_range(0, 3) == 0);
      mtlo_wr = ($urandom_range(0, 3) == 0);
      wdata   = $urandom;
      if (left == 0) begin
        mul_a = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 255)) - 32'd128 : $urandom;
        mul_b = $urandom;
      end
      tick();
    end
    reset = 1'b0; start = 1'b0; mthi_wr = 1'b0; mtlo_wr = 1'b0;
    wait_idle();
    run(3);
    chk("sb_drained", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
